// File: rtl/burst_ram_responder_if.sv
// rtl/burst_ram_responder_if.sv - shared burst bus between an initiator and the RAM responder
interface burst_ram_responder_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        readNotWriteIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
               readNotWriteIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );

    modport slave (
        input  beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
               readNotWriteIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );
endinterface

// File: rtl/burst_ram_responder.sv
// rtl/burst_ram_responder.sv - 1 KiB burst RAM responder on a shared wired-OR address/data bus
module burst_ram_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h40000000
) (
    input  logic                  cpuClock,
    input  logic                  cpuReset,
    burst_ram_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, READ_FIRST, READ_BURST, READ_END, WRITE, ERROR, WAIT_END
    } stateType;

    stateType    state;
    logic [7:0]  baseIndex;
    logic [7:0]  burstCount;
    logic [8:0]  wordCount;
    logic [31:0] ramData;
    logic [31:0] memory [0:255];

    logic [7:0]  wordAddress;
    logic [7:0]  ramAddress;
    logic        ramRead;
    logic        ramWrite;
    logic [8:0]  rangeEnd;
    logic        windowHit;

    // In READ_BURST the RAM runs one word ahead of the word being driven on the bus.
    always_comb begin
        wordAddress = baseIndex + wordCount[7:0];
        ramAddress  = (state == READ_FIRST) ? baseIndex : wordAddress + 8'd1;
        ramRead     = !cpuReset && (state == READ_FIRST || state == READ_BURST);
        ramWrite    = !cpuReset && (state == WRITE) && bus.dataValidIn
                      && (wordCount <= {1'b0, burstCount});
        rangeEnd    = {1'b0, bus.addressDataIn[9:2]} + {1'b0, bus.burstSizeIn};
        windowHit   = (bus.addressDataIn[31:10] == BASE_ADDRESS[31:10]);
    end

    // RAM is deliberately outside the reset domain so contents survive cpuReset.
    always_ff @(posedge cpuClock) begin
        if (ramWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteEnablesIn[b]) begin
                    memory[wordAddress][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
                end
            end
        end
        if (ramRead) begin
            ramData <= memory[ramAddress];
        end
    end

    always_ff @(posedge cpuClock) begin
        if (cpuReset) begin
            state                 <= IDLE;
            baseIndex             <= 8'd0;
            burstCount            <= 8'd0;
            wordCount             <= 9'd0;
            bus.addressDataOut    <= 32'd0;
            bus.dataValidOut      <= 1'b0;
            bus.endTransactionOut <= 1'b0;
            bus.busErrorOut       <= 1'b0;
        end else begin
            bus.addressDataOut    <= 32'd0;
            bus.dataValidOut      <= 1'b0;
            bus.endTransactionOut <= 1'b0;
            bus.busErrorOut       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.beginTransactionIn && windowHit) begin
                        baseIndex  <= bus.addressDataIn[9:2];
                        burstCount <= bus.burstSizeIn;
                        wordCount  <= 9'd0;
                        if (rangeEnd[8]) begin
                            state <= ERROR;
                        end else if (bus.readNotWriteIn) begin
                            state <= READ_FIRST;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                READ_FIRST: begin
                    state <= bus.endTransactionIn ? IDLE : READ_BURST;
                end
                READ_BURST: begin
                    if (bus.endTransactionIn) begin
                        state <= IDLE;
                    end else if (wordCount <= {1'b0, burstCount}) begin
                        bus.dataValidOut   <= 1'b1;
                        bus.addressDataOut <= ramData;
                        wordCount          <= wordCount + 9'd1;
                    end else begin
                        bus.endTransactionOut <= 1'b1;
                        state                 <= READ_END;
                    end
                end
                READ_END: begin
                    state <= IDLE;
                end
                WRITE: begin
                    if (ramWrite) begin
                        wordCount <= wordCount + 9'd1;
                    end
                    if (bus.endTransactionIn) begin
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    bus.busErrorOut <= 1'b1;
                    state           <= WAIT_END;
                end
                WAIT_END: begin
                    if (bus.endTransactionIn) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_burst_ram_responder.sv
// tb/tb_burst_ram_responder.sv - scoreboard bench for burst_ram_responder
module tb_burst_ram_responder;
    localparam logic [31:0] BASE = 32'h40000000;

    logic cpuClock;
    logic cpuReset;
    int   assertionCount = 0;
    int   failureCount = 0;

    logic [31:0] expectedQueue [$];
    logic [31:0] writeQueue [$];
    logic [31:0] model [0:255];

    burst_ram_responder_if bus();

    burst_ram_responder #(.BASE_ADDRESS(BASE)) dut (
        .cpuClock (cpuClock),
        .cpuReset (cpuReset),
        .bus      (bus)
    );

    initial cpuClock = 1'b0;
    always #5 cpuClock = ~cpuClock;

    task automatic checkResult(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertionCount++;
        if (actual !== expected) begin
            failureCount++;
            $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkOutputs(input string tag, input logic expDv, input logic expEo, input logic expBe);
        logic [31:0] expData;
        checkResult({tag, " flags"},
                    {29'd0, bus.dataValidOut, bus.endTransactionOut, bus.busErrorOut},
                    {29'd0, expDv, expEo, expBe});
        if (bus.dataValidOut) begin
            if (expectedQueue.size() > 0) begin
                expData = expectedQueue.pop_front();
                checkResult({tag, " data"}, bus.addressDataOut, expData);
            end else begin
                checkResult({tag, " scoreboard underflow"}, 32'd1, 32'd0);
            end
        end else begin
            checkResult({tag, " idle data"}, bus.addressDataOut, 32'd0);
        end
    endtask

    task automatic idleInputs();
        bus.beginTransactionIn = 1'b0;
        bus.addressDataIn      = 32'd0;
        bus.byteEnablesIn      = 4'd0;
        bus.burstSizeIn        = 8'd0;
        bus.readNotWriteIn     = 1'b0;
        bus.dataValidIn        = 1'b0;
        bus.endTransactionIn   = 1'b0;
    endtask

    // Called one step after a rising edge; returns the same way, in the IDLE cycle.
    task automatic doWrite(input logic [31:0] addr, input logic [7:0] n, input logic [3:0] be);
        int          count;
        logic [31:0] w;
        logic [7:0]  idx;
        count = writeQueue.size();
        idx   = addr[9:2];
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = addr;
        bus.burstSizeIn        = n;
        bus.readNotWriteIn     = 1'b0;
        @(posedge cpuClock); #1;
        bus.beginTransactionIn = 1'b0;
        for (int i = 0; i < count; i++) begin
            w = writeQueue.pop_front();
            bus.dataValidIn      = 1'b1;
            bus.addressDataIn    = w;
            bus.byteEnablesIn    = be;
            bus.endTransactionIn = (i == count - 1);
            if (i <= int'(n)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[idx + 8'(i)][8*b +: 8] = w[8*b +: 8];
                end
            end
            @(negedge cpuClock);
            checkOutputs("write", 1'b0, 1'b0, 1'b0);
            @(posedge cpuClock); #1;
        end
        idleInputs();
    endtask

    // abortCycle < 0: full read; otherwise cpuReset is raised after data cycle T+abortCycle.
    task automatic doRead(input logic [31:0] addr, input logic [7:0] n, input int abortCycle);
        logic [7:0] idx;
        int         lastK;
        idx = addr[9:2];
        for (int i = 0; i <= int'(n); i++) expectedQueue.push_back(model[idx + 8'(i)]);
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = addr;
        bus.burstSizeIn        = n;
        bus.readNotWriteIn     = 1'b1;
        @(posedge cpuClock); #1;
        idleInputs();
        lastK = (abortCycle >= 0) ? abortCycle + 2 : int'(n) + 3;
        for (int k = 0; k <= lastK; k++) begin
            @(negedge cpuClock);
            if (abortCycle >= 0 && k > abortCycle) begin
                checkOutputs("reset abort", 1'b0, 1'b0, 1'b0);
            end else begin
                checkOutputs("read", (k >= 2) && (k <= int'(n) + 2), k == int'(n) + 3, 1'b0);
            end
            if (k == abortCycle) cpuReset = 1'b1;
            if (abortCycle >= 0 && k == abortCycle + 1) cpuReset = 1'b0;
        end
        @(posedge cpuClock); #1;
        if (abortCycle >= 0) begin
            checkResult("words left after abort", 32'(expectedQueue.size()), 32'(int'(n) + 2 - abortCycle));
            expectedQueue.delete();
        end else begin
            checkResult("scoreboard drained", 32'(expectedQueue.size()), 32'd0);
        end
    endtask

    task automatic doQuiet(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge cpuClock);
            checkOutputs(tag, 1'b0, 1'b0, 1'b0);
        end
        @(posedge cpuClock); #1;
    endtask

    task automatic doErrorRead(input logic [31:0] addr, input logic [7:0] n);
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = addr;
        bus.burstSizeIn        = n;
        bus.readNotWriteIn     = 1'b1;
        @(posedge cpuClock); #1;
        idleInputs();
        for (int k = 0; k <= 4; k++) begin
            @(negedge cpuClock);
            checkOutputs("range error", 1'b0, 1'b0, k == 1);
        end
        @(posedge cpuClock); #1;
        // still in WAIT_END: a legal begin must be ignored
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = BASE;
        bus.readNotWriteIn     = 1'b1;
        @(posedge cpuClock); #1;
        idleInputs();
        doQuiet("wait end", 4);
        bus.endTransactionIn = 1'b1;
        @(posedge cpuClock); #1;
        idleInputs();
    endtask

    initial begin
        idleInputs();
        cpuReset = 1'b1;
        repeat (3) @(posedge cpuClock);
        @(negedge cpuClock);
        checkOutputs("reset state", 1'b0, 1'b0, 1'b0);
        @(posedge cpuClock); #1;
        cpuReset = 1'b0;

        // burst write then back-to-back burst read
        writeQueue = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        doWrite(BASE + 32'h10, 8'd3, 4'hF);
        doRead(BASE + 32'h10, 8'd3, -1);

        // partial byte enables over a zeroed word
        writeQueue = '{32'h00000000};
        doWrite(BASE + 32'h20, 8'd0, 4'hF);
        writeQueue = '{32'hAABBCCDD};
        doWrite(BASE + 32'h20, 8'd0, 4'b0101);
        doRead(BASE + 32'h20, 8'd0, -1);

        // write overrun: third word discarded
        writeQueue = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2};
        doWrite(BASE + 32'hA0, 8'd2, 4'hF);
        writeQueue = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        doWrite(BASE + 32'hA0, 8'd1, 4'hF);
        doRead(BASE + 32'hA0, 8'd2, -1);

        // range error at the top of the window leaves RAM intact
        writeQueue = '{32'h0BAD0000, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003};
        doWrite(BASE + 32'h3F0, 8'd3, 4'hF);
        doErrorRead(BASE + 32'h3F0, 8'd8);
        doRead(BASE + 32'h3F0, 8'd3, -1);

        // out-of-window begin is ignored, next in-window begin accepted
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = BASE + 32'h400;
        bus.readNotWriteIn     = 1'b1;
        @(posedge cpuClock); #1;
        idleInputs();
        doQuiet("outside window", 5);
        doRead(BASE + 32'h10, 8'd0, -1);

        // reset during a 16-word read, then a full re-read
        for (int i = 0; i < 16; i++) writeQueue.push_back(32'h5A000000 + 32'(i) * 32'h00010101);
        doWrite(BASE + 32'h100, 8'd15, 4'hF);
        doRead(BASE + 32'h100, 8'd15, 4);
        doRead(BASE + 32'h100, 8'd15, -1);

        // random data with a random byte-enable overlay
        for (int i = 0; i < 8; i++) writeQueue.push_back($urandom);
        doWrite(BASE + 32'h200, 8'd7, 4'hF);
        for (int i = 0; i < 8; i++) writeQueue.push_back($urandom);
        doWrite(BASE + 32'h200, 8'd7, 4'($urandom_range(1, 14)));
        doRead(BASE + 32'h200, 8'd7, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end
endmodule
